// File: rtl/ship_pixel_gen.sv
// Ship + single-bullet pixel generator sitting behind the VGA timing block.
// Optional macro SHIP_AUTOFIRE_EN: a held fire button re-arms a shot on every frame tick.
module ship_pixel_gen #(
  parameter int SHIP_W       = 16,
  parameter int SHIP_H       = 8,
  parameter int SHIP_Y       = 228,
  parameter int SHIP_SPEED   = 2,
  parameter int BULLET_W     = 2,
  parameter int BULLET_H     = 4,
  parameter int BULLET_SPEED = 4,
  parameter int H_LAST       = 298
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] H_pos,
  input  logic [8:0] V_pos,
  input  logic       VGA_enable,
  input  logic       H_sync,
  input  logic       V_sync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic [2:0] rgb,
  output logic       H_sync_o,
  output logic       V_sync_o
);

  typedef enum logic {BULLET_IDLE, BULLET_FLYING} bullet_state_e;

  localparam logic [9:0] SHIP_X_MAX   = 10'(H_LAST + 1 - SHIP_W);
  localparam logic [8:0] SHIP_X_RESET = 9'd141;
  localparam logic [9:0] SHIP_STEP    = 10'(SHIP_SPEED);

  // Button vectors are packed {fire, right, left}
  logic [2:0]    btn_sync1_q, btn_sync1_d;
  logic [2:0]    btn_sync2_q, btn_sync2_d;
  logic          fire_prev_q, fire_prev_d;
  logic          fire_pending_q, fire_pending_d;
  logic [8:0]    ship_x_q, ship_x_d;
  bullet_state_e bullet_state_q, bullet_state_d;
  logic [8:0]    bx_q, bx_d;
  logic [8:0]    by_q, by_d;
  logic          v_sync_prev_q, v_sync_prev_d;
  logic          v_sync_q, v_sync_d;
  logic          h_sync_q, h_sync_d;
  logic [2:0]    rgb_q, rgb_d;

  logic       tick, fire_edge, launch_req, move_left, move_right;
  logic       ship_hit, bullet_hit;
  logic [2:0] colour;
  logic [9:0] ship_x_ext, bx_ext, by_ext, h_ext, v_ext;

  always_comb begin
    btn_sync1_d   = {btn_fire, btn_right, btn_left};
    btn_sync2_d   = btn_sync1_q;
    fire_prev_d   = btn_sync2_q[2];
    v_sync_d      = V_sync;
    v_sync_prev_d = v_sync_q;
    h_sync_d      = H_sync;

    tick       = v_sync_prev_q & ~v_sync_q;
    fire_edge  = btn_sync2_q[2] & ~fire_prev_q;
    move_left  = btn_sync2_q[0] & ~btn_sync2_q[1];
    move_right = btn_sync2_q[1] & ~btn_sync2_q[0];
`ifdef SHIP_AUTOFIRE_EN
    launch_req = fire_pending_q | fire_edge | btn_sync2_q[2];
`else
    launch_req = fire_pending_q | fire_edge;
`endif
    // A request not consumed by the tick is dropped, so presses during flight vanish
    fire_pending_d = tick ? 1'b0 : (fire_pending_q | fire_edge);

    ship_x_ext = {1'b0, ship_x_q};
    ship_x_d   = ship_x_q;
    if (tick && move_left) begin
      ship_x_d = (ship_x_ext >= SHIP_STEP) ? 9'(ship_x_ext - SHIP_STEP) : 9'd0;
    end else if (tick && move_right) begin
      ship_x_d = (ship_x_ext + SHIP_STEP > SHIP_X_MAX) ? SHIP_X_MAX[8:0]
                                                       : 9'(ship_x_ext + SHIP_STEP);
    end

    bullet_state_d = bullet_state_q;
    bx_d           = bx_q;
    by_d           = by_q;
    if (tick) begin
      case (bullet_state_q)
        BULLET_IDLE: begin
          if (launch_req) begin
            bullet_state_d = BULLET_FLYING;
            bx_d           = 9'(ship_x_ext + 10'(SHIP_W / 2 - 1));
            by_d           = 9'(SHIP_Y - BULLET_H);
          end
        end
        BULLET_FLYING: begin
          if (by_q < 9'(BULLET_SPEED)) begin
            bullet_state_d = BULLET_IDLE;
          end else begin
            by_d = by_q - 9'(BULLET_SPEED);
          end
        end
      endcase
    end

    h_ext  = {1'b0, H_pos};
    v_ext  = {1'b0, V_pos};
    bx_ext = {1'b0, bx_q};
    by_ext = {1'b0, by_q};
    ship_hit = (h_ext >= ship_x_ext) && (h_ext < ship_x_ext + 10'(SHIP_W)) &&
               (v_ext >= 10'(SHIP_Y)) && (v_ext < 10'(SHIP_Y + SHIP_H));
    bullet_hit = (bullet_state_q == BULLET_FLYING) &&
                 (h_ext >= bx_ext) && (h_ext < bx_ext + 10'(BULLET_W)) &&
                 (v_ext >= by_ext) && (v_ext < by_ext + 10'(BULLET_H));
    colour = bullet_hit ? 3'b110 : (ship_hit ? 3'b010 : 3'b000);
    rgb_d  = VGA_enable ? colour : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_q    <= 3'b000;
      btn_sync2_q    <= 3'b000;
      fire_prev_q    <= 1'b0;
      fire_pending_q <= 1'b0;
      ship_x_q       <= SHIP_X_RESET;
      bullet_state_q <= BULLET_IDLE;
      bx_q           <= 9'd0;
      by_q           <= 9'd0;
      v_sync_prev_q  <= 1'b0;
      v_sync_q       <= 1'b0;
      h_sync_q       <= 1'b0;
      rgb_q          <= 3'b000;
    end else begin
      btn_sync1_q    <= btn_sync1_d;
      btn_sync2_q    <= btn_sync2_d;
      fire_prev_q    <= fire_prev_d;
      fire_pending_q <= fire_pending_d;
      ship_x_q       <= ship_x_d;
      bullet_state_q <= bullet_state_d;
      bx_q           <= bx_d;
      by_q           <= by_d;
      v_sync_prev_q  <= v_sync_prev_d;
      v_sync_q       <= v_sync_d;
      h_sync_q       <= h_sync_d;
      rgb_q          <= rgb_d;
    end
  end

  assign rgb      = rgb_q;
  assign H_sync_o = h_sync_q;
  assign V_sync_o = v_sync_q;

endmodule

// File: tb/tb_ship_pixel_gen.sv
// Self-checking bench for ship_pixel_gen: compressed frames (short V_sync pulses) with
// pixel probes compared against a frame-level model of ship and bullet. Honours SHIP_AUTOFIRE_EN.
module tb_ship_pixel_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] H_pos, V_pos;
  logic       VGA_enable, H_sync, V_sync;
  logic       btn_left, btn_right, btn_fire;
  logic [2:0] rgb;
  logic       H_sync_o, V_sync_o;

  int checkCount = 0;
  int passCount  = 0;

  // Frame-level model of the game state
  int mShipX;
  int mBx;
  int mBy;
  bit mFlying;
  bit mLastFire;

  ship_pixel_gen dut (
    .clk(clk), .rst_n(rst_n),
    .H_pos(H_pos), .V_pos(V_pos), .VGA_enable(VGA_enable),
    .H_sync(H_sync), .V_sync(V_sync),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .rgb(rgb), .H_sync_o(H_sync_o), .V_sync_o(V_sync_o)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mShipX    = 141;
    mBx       = 0;
    mBy       = 0;
    mFlying   = 1'b0;
    mLastFire = 1'b0;
  endtask

  task automatic modelTick(input bit l, input bit r, input bit fireRise, input bit fireHeld);
    bit launch;
    launch = fireRise;
`ifdef SHIP_AUTOFIRE_EN
    launch = launch | fireHeld;
`endif
    if (mFlying) begin
      if (mBy < 4) mFlying = 1'b0;
      else mBy = mBy - 4;
    end else if (launch) begin
      mFlying = 1'b1;
      mBx     = mShipX + 7;
      mBy     = 224;
    end
    if (l && !r) mShipX = (mShipX >= 2) ? mShipX - 2 : 0;
    else if (r && !l) mShipX = (mShipX + 2 > 283) ? 283 : mShipX + 2;
  endtask

  function automatic logic [2:0] refColour(input int h, input int v, input bit en);
    if (!en) return 3'b000;
    if (mFlying && h >= mBx && h < mBx + 2 && v >= mBy && v < mBy + 4) return 3'b110;
    if (h >= mShipX && h < mShipX + 16 && v >= 228 && v < 236) return 3'b010;
    return 3'b000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Drives one pixel on a falling edge and checks the registered colour/hsync one clk later.
  // A non-negative fixedExp replaces the model's expectation for directed checks.
  task automatic probe(input string tag, input int h, input int v, input bit en, input int fixedExp);
    int hh, vv;
    bit hs;
    logic [2:0] exp;
    hh = (h < 0) ? 0 : ((h > 298) ? 298 : h);
    vv = (v < 0) ? 0 : ((v > 237) ? 237 : v);
    hs = 1'($urandom_range(0, 1));
    exp = (fixedExp >= 0) ? 3'(fixedExp) : refColour(hh, vv, en);
    H_pos = 9'(hh);
    V_pos = 9'(vv);
    VGA_enable = en;
    H_sync = hs;
    @(negedge clk);
    checkOutput(tag, rgb, exp);
    checkOutput("hsync_o", H_sync_o, hs);
  endtask

  // One compressed frame: buttons held, V_sync pulse, tick on its falling edge
  task automatic applyStimulus(input bit l, input bit r, input bit f, input bit sameClk);
    btn_left = l;
    btn_right = r;
    if (!sameClk) btn_fire = f;
    H_pos = 9'd0;
    V_pos = 9'd0;
    VGA_enable = 1'b0;
    V_sync = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("vsync_o_high", V_sync_o, 1);
    if (sameClk) begin
      btn_fire = f;
      @(negedge clk);
    end
    V_sync = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("vsync_o_low", V_sync_o, 0);
    modelTick(l, r, f && !mLastFire, f);
    mLastFire = f;
  endtask

  task automatic checkFrame(input int nRandom);
    probe("ship_tl", mShipX, 228, 1'b1, -1);
    probe("ship_br", mShipX + 15, 235, 1'b1, -1);
    probe("ship_left_out", mShipX - 1, 230, 1'b1, -1);
    probe("ship_right_out", mShipX + 16, 230, 1'b1, -1);
    probe("ship_above", mShipX + 5, 227, 1'b1, -1);
    probe("ship_below", mShipX + 5, 236, 1'b1, -1);
    probe("ship_blank", mShipX + 3, 230, 1'b0, -1);
    if (mFlying) begin
      probe("bullet_tl", mBx, mBy, 1'b1, -1);
      probe("bullet_br", mBx + 1, mBy + 3, 1'b1, -1);
      probe("bullet_right_out", mBx + 2, mBy + 1, 1'b1, -1);
      probe("bullet_below", mBx, mBy + 4, 1'b1, -1);
      probe("bullet_left_out", mBx - 1, mBy, 1'b1, -1);
    end
    for (int i = 0; i < nRandom; i++)
      probe("random_px", $urandom_range(0, 298), $urandom_range(0, 237), ($urandom_range(0, 7) != 0), -1);
  endtask

  initial begin
    rst_n = 1'b0;
    H_pos = 9'd0; V_pos = 9'd0; VGA_enable = 1'b0;
    H_sync = 1'b0; V_sync = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_rgb", rgb, 0);
    checkOutput("reset_hsync", H_sync_o, 0);
    checkOutput("reset_vsync", V_sync_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] idle frames after reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkFrame(4);
    end
    probe("ship_col141", 141, 228, 1'b1, 2);
    probe("ship_col156", 156, 235, 1'b1, 2);
    probe("ship_col140", 140, 228, 1'b1, 0);
    probe("ship_col157", 157, 235, 1'b1, 0);
    probe("ship_row236", 150, 236, 1'b1, 0);
    probe("ship_disabled", 150, 230, 1'b0, 0);

    $display("[TB] hold left, then right, then both");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkFrame(0);
    end
    probe("ship_at_left_edge", 0, 228, 1'b1, 2);
    probe("ship_left_edge_end", 16, 228, 1'b1, 0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (i % 10 == 0) checkFrame(1);
    end
    checkFrame(0);
    probe("ship_at_right_edge", 298, 235, 1'b1, 2);
    probe("ship_right_edge_start", 282, 235, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkFrame(0);
    end
    for (int i = 0; i < 71; i++) applyStimulus(1, 0, 0, 0);
    checkFrame(2);

    $display("[TB] single shot, press during flight, held fire");
    applyStimulus(0, 0, 1, 0);
    checkFrame(2);
    probe("bullet_launch_px", 148, 224, 1'b1, 6);
    probe("bullet_launch_px2", 149, 227, 1'b1, 6);
    probe("bullet_launch_out", 150, 224, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkFrame(0);
    end
    applyStimulus(0, 0, 0, 0);
    checkFrame(0);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkFrame(0);
    end
    for (int i = 0; i < 80 && mFlying; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkFrame(0);
    end

    $display("[TB] press on the tick clock");
    applyStimulus(0, 0, 1, 1);
    checkFrame(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkFrame(0);
    end

    $display("[TB] random frames");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      checkFrame(3);
    end

    $display("[TB] reset during flight");
    if (!mFlying) begin
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
    end
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    H_pos = 9'(mBx); V_pos = 9'(mBy); VGA_enable = 1'b1; H_sync = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_rgb", rgb, 6);
    checkOutput("pre_reset_hsync", H_sync_o, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rgb", rgb, 0);
    checkOutput("async_reset_hsync", H_sync_o, 0);
    checkOutput("async_reset_vsync", V_sync_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    probe("post_reset_old_bullet", mBx, mBy, 1'b1, -1);
    checkFrame(2);
    probe("post_reset_ship", 141, 228, 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkFrame(2);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
